// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: stage/butterfly sequencer for an in-place radix-2 DIF FFT.
// Issues one butterfly command per accepted handshake, counts outstanding
// write-backs and drains them before every stage change.
//
// Handshake: a command is transferred on a rising clock edge where
// o_valid && i_ready. While o_valid is high and i_ready is low, every command
// field (o_addr_a, o_addr_b, o_exponent, o_stage, o_last) holds its value.
// o_valid never drops without a transfer.
module fft_stage_ctrl #(
  parameter int R = 5,
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [R-1:0] o_addr_a,
  output logic [R-1:0] o_addr_b,
  output logic [R-2:0] o_exponent,
  output logic [3:0]   o_stage,
  output logic         o_last,
  input  logic         i_wb_done,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0]   S_LAST = 4'(R - 1);
  localparam logic [R-2:0] B_LAST = (R-1)'(N / 2 - 1);
  localparam logic [R-2:0] B_ONE  = (R-1)'(1);
  localparam logic [R-1:0] C_ONE  = R'(1);

  state_t       state_q, state_d;
  logic [3:0]   s_q, s_d;
  logic [R-2:0] b_q, b_d;
  logic [R-1:0] cnt_q, cnt_d;
  logic [R-1:0] addr_a_q, addr_a_d;
  logic [R-1:0] addr_b_q, addr_b_d;
  logic [R-2:0] exp_q, exp_d;
  logic         last_q, last_d;

  logic         accept;
  logic         wb_eff;
  logic [3:0]   sh;
  logic [R-2:0] k_mask;
  logic [R-2:0] k;
  logic [R-1:0] h;
  logic [R-1:0] g_part;
  logic [R-1:0] a_calc;

  assign accept = (state_q == ISSUE) && i_ready;
  // A write-back reported with nothing outstanding is spurious and dropped.
  assign wb_eff = i_wb_done && (cnt_q != '0);

  // Next stage / butterfly index and state transitions.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ISSUE;
          s_d     = '0;
          b_d     = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (b_q == B_LAST) begin
            b_d     = '0;
            state_d = DRAIN;
          end else begin
            b_d = b_q + B_ONE;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          if (s_q == S_LAST) begin
            state_d = FINISH;
          end else begin
            s_d     = s_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command fields for the next cycle's (s, b): H = 1 << (R-1-s), k = low bits
  // of b below H, group index shifted up by one extra bit to skip the lower leg.
  always_comb begin
    sh       = S_LAST - s_d;
    k_mask   = ~({(R-1){1'b1}} << sh);
    k        = b_d & k_mask;
    h        = C_ONE << sh;
    g_part   = ({1'b0, b_d} >> sh) << (sh + 4'd1);
    a_calc   = g_part | {1'b0, k};
    addr_a_d = '0;
    addr_b_d = '0;
    exp_d    = '0;
    last_d   = 1'b0;
    if (state_d == ISSUE) begin
      addr_a_d = a_calc;
      addr_b_d = a_calc | h;
      exp_d    = k << s_d;
      last_d   = (b_d == B_LAST);
    end
  end

  // Outstanding write-back counter; accept and write-back together cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !wb_eff) begin
      cnt_d = cnt_q + C_ONE;
    end else if (!accept && wb_eff) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  // State, index, counter and registered command fields.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      exp_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      exp_q    <= exp_d;
      last_q   <= last_d;
    end
  end

  assign o_valid     = (state_q == ISSUE);
  assign o_busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign o_done      = (state_q == FINISH);
  assign o_addr_a    = addr_a_q;
  assign o_addr_b    = addr_b_q;
  assign o_exponent  = exp_q;
  assign o_stage     = s_q;
  assign o_last      = last_q;
  assign o_dbg_state = state_q;

endmodule
